// File: rtl/lap_recall.sv
// Lap recall controller: steps through stored lap records, fetches each one from the lap store and drives an 8-digit display.
// Optional feature: define LAP_INDEX_EN to show the 1-based lap number on digit 3 (otherwise a dash is shown).
module lap_recall (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_btn,
    input  logic        exit_btn,
    input  logic [3:0]  lap_count,
    output logic        rd_req,
    output logic [2:0]  rd_addr,
    input  logic        rd_valid,
    input  logic [23:0] rd_data,
    output logic [3:0]  out1,
    output logic [3:0]  out2,
    output logic [3:0]  out3,
    output logic [3:0]  out4,
    output logic [3:0]  out5,
    output logic [3:0]  out6,
    output logic [3:0]  out7,
    output logic [3:0]  out8,
    output logic        en
);

    localparam logic [3:0] BLANK = 4'hF;
    localparam logic [3:0] DASH  = 4'hA;
    localparam logic [3:0] ERR   = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic [23:0] rec;
    logic        shown;
    logic        latch;
    logic [3:0]  eff_count;
    logic        last_lap;

`ifdef LAP_INDEX_EN
    logic [2:0]  rec_idx;
`endif

    function automatic logic [3:0] digit(input logic [3:0] n);
        return (n > 4'd9) ? ERR : n;
    endfunction

    // Counts above 8 saturate; a shrinking count makes the next step wrap to lap 0.
    assign eff_count = (lap_count > 4'd8) ? 4'd8 : lap_count;
    assign last_lap  = (({1'b0, idx} + 4'd1) >= eff_count);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (next_btn && (eff_count != 4'd0)) begin
                    state_nxt = FETCH;
                    idx_nxt   = 3'd0;
                end
            end
            FETCH: begin
                // Exit beats a simultaneous rd_valid so the pending record is dropped.
                if (exit_btn) begin
                    state_nxt = IDLE;
                    idx_nxt   = 3'd0;
                end else if (rd_valid) begin
                    state_nxt = SHOW;
                    latch     = 1'b1;
                end
            end
            SHOW: begin
                if (exit_btn) begin
                    state_nxt = IDLE;
                    idx_nxt   = 3'd0;
                end else if (next_btn) begin
                    state_nxt = FETCH;
                    idx_nxt   = last_lap ? 3'd0 : (idx + 3'd1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 3'd0;
            rec   <= 24'd0;
            shown <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (latch) begin
                rec   <= rd_data;
                shown <= 1'b1;
            end else if (state_nxt == IDLE) begin
                shown <= 1'b0;
            end
        end
    end

`ifdef LAP_INDEX_EN
    // The index travels with the record so a refetch keeps the old lap number on screen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_idx <= 3'd0;
        end else if (latch) begin
            rec_idx <= idx;
        end
    end
`endif

    assign rd_req  = (state == FETCH);
    assign rd_addr = idx;

    // While a new lap is being fetched the previous record stays visible.
    assign en = (state == SHOW) || ((state == FETCH) && shown);

    always_comb begin
        out1 = BLANK;
        out2 = BLANK;
        out3 = BLANK;
        out4 = BLANK;
        out5 = BLANK;
        out6 = BLANK;
        out7 = BLANK;
        out8 = BLANK;
        if (en) begin
            out1 = digit(rec[23:20]);
            out2 = digit(rec[19:16]);
            out4 = digit(rec[15:12]);
            out5 = digit(rec[11:8]);
            out6 = DASH;
            out7 = digit(rec[7:4]);
            out8 = digit(rec[3:0]);
`ifdef LAP_INDEX_EN
            out3 = {1'b0, rec_idx} + 4'd1;
`else
            out3 = DASH;
`endif
        end
    end

endmodule

// File: tb/tb_lap_recall.sv
// Self-checking bench for lap_recall: directed scenarios plus randomized traffic against a lap-level reference model.
module tb_lap_recall;

    logic        clk;
    logic        rst;
    logic        next_btn;
    logic        exit_btn;
    logic [3:0]  lap_count;
    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic [3:0]  out1, out2, out3, out4, out5, out6, out7, out8;
    logic        en;

    int checks;
    int failures;

    // Reference model: "in recall mode", "waiting for data", "have a record on screen".
    bit          m_active;
    bit          m_wait;
    bit          m_has;
    int          m_lap;
    logic [23:0] m_rec;
    int          m_rec_lap;

    lap_recall dut (
        .clk       (clk),
        .rst       (rst),
        .next_btn  (next_btn),
        .exit_btn  (exit_btn),
        .lap_count (lap_count),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out8      (out8),
        .en        (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] nib(input logic [3:0] d);
        return (d > 4'd9) ? 4'hE : d;
    endfunction

    task automatic model_reset();
        m_active  = 0;
        m_wait    = 0;
        m_has     = 0;
        m_lap     = 0;
        m_rec     = 24'd0;
        m_rec_lap = 0;
    endtask

    task automatic model_update(input logic nb, input logic eb, input logic [3:0] lc,
                                input logic rv, input logic [23:0] rd);
        int laps;
        laps = (lc > 8) ? 8 : int'(lc);
        if (!m_active) begin
            if (nb && laps != 0) begin
                m_active = 1;
                m_wait   = 1;
                m_lap    = 0;
            end
        end else if (eb) begin
            m_active = 0;
            m_wait   = 0;
            m_has    = 0;
            m_lap    = 0;
        end else if (m_wait) begin
            if (rv) begin
                m_rec     = rd;
                m_rec_lap = m_lap;
                m_has     = 1;
                m_wait    = 0;
            end
        end else if (nb) begin
            m_lap  = (m_lap + 1 < laps) ? m_lap + 1 : 0;
            m_wait = 1;
        end
    endtask

    function automatic logic exp_req();
        return m_active && m_wait;
    endfunction

    function automatic logic [36:0] exp_vec();
        logic [31:0] d;
        logic        shw;
        logic [3:0]  o3;
        shw = m_active && m_has;
        d   = {8{4'hF}};
`ifdef LAP_INDEX_EN
        o3 = 4'(m_rec_lap + 1);
`else
        o3 = 4'hA;
`endif
        if (shw)
            d = {nib(m_rec[23:20]), nib(m_rec[19:16]), o3, nib(m_rec[15:12]),
                 nib(m_rec[11:8]), 4'hA, nib(m_rec[7:4]), nib(m_rec[3:0])};
        return {exp_req(), exp_req() ? 3'(m_lap) : 3'd0, shw, d};
    endfunction

    // rd_addr only has meaning while a read is being requested.
    function automatic logic [36:0] dut_vec();
        return {rd_req, rd_addr & {3{exp_req()}}, en, out1, out2, out3, out4, out5, out6, out7, out8};
    endfunction

    // Drive one cycle of inputs from a negedge, advance the model at the posedge, return at the next negedge.
    task automatic step(input logic nb, input logic eb, input logic rv, input logic [23:0] rd);
        next_btn = nb;
        exit_btn = eb;
        rd_valid = rv;
        rd_data  = rd;
        @(posedge clk);
        model_update(nb, eb, lap_count, rv, rd);
        @(negedge clk);
        next_btn = 1'b0;
        exit_btn = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        next_btn  = 1'b0;
        exit_btn  = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = 24'd0;
        lap_count = 4'd3;
        model_reset();
        @(negedge clk);
        checks++;
        if ({rd_req, en, out1, out2, out3, out4, out5, out6, out7, out8} !== {2'b00, {8{4'hF}}}) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual=%h required=%h",
                     {rd_req, en, out1, out2, out3, out4, out5, out6, out7, out8}, {2'b00, {8{4'hF}}});
        end
        checks++;
        if (rd_addr !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_rd_addr actual=%0d required=0", rd_addr);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 24'd0);
            checks++;
            if ((rd_req !== 1'b0) || (en !== 1'b0)) begin
                failures++;
                $display("[TB] FAIL reset_needs_next actual=%b%b required=00", rd_req, en);
            end
        end
    endtask

    task automatic test_zero_count();
        lap_count = 4'd0;
        step(1'b1, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ((rd_req !== 1'b0) || (en !== 1'b0)) begin
                failures++;
                $display("[TB] FAIL zero_count actual=%b%b required=00", rd_req, en);
            end
            step(1'b0, 1'b0, 1'b1, 24'h123456);
        end
    endtask

    task automatic test_basic();
        lap_count = 4'd3;
        step(1'b1, 1'b0, 1'b0, 24'd0);
        checks++;
        if ((rd_req !== 1'b1) || (rd_addr !== 3'd0) || (en !== 1'b0)) begin
            failures++;
            $display("[TB] FAIL basic_request actual=req%b addr%0d en%b required=req1 addr0 en0", rd_req, rd_addr, en);
        end
        step(1'b0, 1'b0, 1'b0, 24'd0);
        checks++;
        if (rd_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_req_held actual=%b required=1", rd_req);
        end
        step(1'b0, 1'b0, 1'b1, 24'h012345);
        checks++;
        if ({rd_req, en, out1, out2, out4, out5, out6, out7, out8} !==
            {1'b0, 1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5}) begin
            failures++;
            $display("[TB] FAIL basic_display actual=%h required=%h",
                     {rd_req, en, out1, out2, out4, out5, out6, out7, out8},
                     {1'b0, 1'b1, 4'h0, 4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5});
        end
        checks++;
`ifdef LAP_INDEX_EN
        if (out3 !== 4'h1) begin
            failures++;
            $display("[TB] FAIL basic_out3 actual=%h required=1", out3);
        end
`else
        if (out3 !== 4'hA) begin
            failures++;
            $display("[TB] FAIL basic_out3 actual=%h required=a", out3);
        end
`endif
    endtask

    task automatic test_sequence();
        int exp_seq[4] = '{1, 2, 0, 1};
        int gap;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 24'd0);
            checks++;
            if ((rd_req !== 1'b1) || (rd_addr !== 3'(exp_seq[i]))) begin
                failures++;
                $display("[TB] FAIL seq_addr%0d actual=req%b addr%0d required=req1 addr%0d", i, rd_req, rd_addr, exp_seq[i]);
            end
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step(1'b1, 1'b0, 1'b0, 24'd0);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    failures++;
                    $display("[TB] FAIL seq_hold actual=%h required=%h", dut_vec(), exp_vec());
                end
            end
            step(1'b0, 1'b0, 1'b1, 24'($urandom));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL seq_show actual=%h required=%h", dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_exit_wins();
        step(1'b1, 1'b1, 1'b0, 24'd0);
        checks++;
        if ({rd_req, en, out1, out2, out3, out4, out5, out6, out7, out8} !== {2'b00, {8{4'hF}}}) begin
            failures++;
            $display("[TB] FAIL exit_wins actual=%h required=%h",
                     {rd_req, en, out1, out2, out3, out4, out5, out6, out7, out8}, {2'b00, {8{4'hF}}});
        end
        step(1'b0, 1'b0, 1'b0, 24'd0);
        checks++;
        if (rd_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL exit_wins_idle actual=%b required=0", rd_req);
        end
    endtask

    task automatic test_error_digit();
        lap_count = 4'd5;
        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b0, 1'b1, 24'h0C5999);
        checks++;
        if ({en, out1, out2, out4, out5, out6, out7, out8} !== {1'b1, 4'h0, 4'hE, 4'h5, 4'h9, 4'hA, 4'h9, 4'h9}) begin
            failures++;
            $display("[TB] FAIL error_digit actual=%h required=%h",
                     {en, out1, out2, out4, out5, out6, out7, out8}, {1'b1, 4'h0, 4'hE, 4'h5, 4'h9, 4'hA, 4'h9, 4'h9});
        end
        step(1'b0, 1'b1, 1'b0, 24'd0);
    endtask

    task automatic test_exit_fetch();
        lap_count = 4'd4;
        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b1, 1'b1, 24'h111111);
        checks++;
        if ((rd_req !== 1'b0) || (en !== 1'b0) || (out1 !== 4'hF)) begin
            failures++;
            $display("[TB] FAIL exit_fetch actual=req%b en%b out1=%h required=req0 en0 out1=f", rd_req, en, out1);
        end
        step(1'b0, 1'b0, 1'b1, 24'h222222);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL stray_valid actual=%h required=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_shrink();
        lap_count = 4'd8;
        step(1'b1, 1'b0, 1'b0, 24'd0);
        step(1'b0, 1'b0, 1'b1, 24'h000001);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 24'd0);
            step(1'b0, 1'b0, 1'b1, 24'(i));
        end
        lap_count = 4'd2;
        step(1'b1, 1'b0, 1'b0, 24'd0);
        checks++;
        if ((rd_req !== 1'b1) || (rd_addr !== 3'd0)) begin
            failures++;
            $display("[TB] FAIL shrink_wrap actual=req%b addr%0d required=req1 addr0", rd_req, rd_addr);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL shrink_hold actual=%h required=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_fetch();
        checks++;
        if (rd_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_fetch_setup actual=%b required=1", rd_req);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({rd_req, rd_addr, en, out1, out2, out3, out4, out5, out6, out7, out8} !== {5'b0, {8{4'hF}}}) begin
            failures++;
            $display("[TB] FAIL reset_mid_fetch actual=%h required=%h",
                     {rd_req, rd_addr, en, out1, out2, out3, out4, out5, out6, out7, out8}, {5'b0, {8{4'hF}}});
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 24'h333333);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("[TB] FAIL after_reset actual=%h required=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0)
                lap_count = 4'($urandom_range(0, 15));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0, 24'($urandom));
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("[TB] FAIL random_cycle%0d actual=%h required=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero_count();
        test_basic();
        test_sequence();
        test_exit_wins();
        test_error_digit();
        test_exit_fetch();
        test_shrink();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lap_recall.md
LAP_RECALL -- requirements
Module: lap_recall

Interface
REQ-001 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port next_btn  input  1  one-cycle synchronous pulse (already debounced), step to next lap.
REQ-004 SHALL have port exit_btn  input  1  one-cycle synchronous pulse, leave recall mode.
REQ-005 SHALL have port lap_count  input  4  number of valid stored laps, 0..8; values above 8 treated as 8.
REQ-006 SHALL have port rd_req  output  1  read request to lap store, held high until rd_valid.
REQ-007 SHALL have port rd_addr  output  3  lap slot being read, 0..7, stable while rd_req high.
REQ-008 SHALL have port rd_valid  input  1  lap store data-valid strobe, one cycle.
REQ-009 SHALL have port rd_data  input  24  stored lap record, six BCD nibbles, MSB first.
REQ-010 SHALL have ports out1..out8  output  4 each  display digit codes, out1 leftmost.
REQ-011 SHALL have port en  output  1  high while a lap record is being shown.

Function
REQ-012 SHALL implement states IDLE, FETCH, SHOW.
REQ-013 IDLE: rd_req=0, en=0, out1..out8=4'hF (blank code).
REQ-014 IDLE + next_btn + lap_count!=0 -> idx=0, FETCH next cycle; next_btn with lap_count=0 ignored, stay IDLE.
REQ-015 FETCH: rd_req=1, rd_addr=idx; on rd_valid latch rd_data into display register, drop rd_req same edge, enter SHOW.
REQ-016 FETCH SHALL wait indefinitely for rd_valid; rd_valid outside FETCH ignored.
REQ-017 next_btn during FETCH ignored; exit_btn during FETCH -> IDLE, rd_req low next cycle, pending data discarded.
REQ-018 SHOW: en=1; out1=[23:20], out2=[19:16], out4=[15:12], out5=[11:8], out7=[7:4], out8=[3:0] of latched record.
REQ-019 SHOW: out6=4'hA (dash code); out3 per REQ-027/028.
REQ-020 SHOW + next_btn -> idx=idx+1, or 0 when idx=lap_count-1 (wrap); FETCH next cycle; display holds old record until new rd_valid.
REQ-021 SHOW + exit_btn -> IDLE; next_btn and exit_btn same cycle -> exit wins.
REQ-022 Latency: next_btn in IDLE/SHOW to rd_req high = 1 cycle; rd_valid to updated outputs and en = 1 cycle.
REQ-023 lap_count reduced below idx+1 while in SHOW -> next next_btn wraps idx to 0.
REQ-024 Any latched nibble >9 SHALL display 4'hE on that digit (error code); raw data retained.

Reset
REQ-025 rst high SHALL immediately force IDLE, idx=0, rd_req=0, rd_addr=0, en=0, out1..out8=4'hF, display register=0, regardless of state (incl. mid-FETCH).
REQ-026 First state change after rst deassert SHALL require a fresh next_btn pulse.

Configuration
REQ-027 With LAP_INDEX_EN defined: in SHOW out3 = idx+1 as BCD (4'h1..4'h8).
REQ-028 Without LAP_INDEX_EN: out3 = 4'hA in SHOW, no index logic synthesized.

Verification
REQ-029 Reset mid-FETCH with rd_req=1 -> rd_req=0, en=0, all outs 4'hF same cycle, state IDLE after release.
REQ-030 lap_count=0, next_btn pulse -> rd_req stays 0, en stays 0.
REQ-031 lap_count=3, next_btn, rd_valid with rd_data=24'h012345 two cycles later -> rd_addr=0, outs 0,1,(1 or A),2,3,A,4,5, en=1 next cycle.
REQ-032 lap_count=3, four next_btn steps from SHOW idx=0 -> rd_addr sequence 1,2,0,1.
REQ-033 SHOW, next_btn and exit_btn same cycle -> IDLE, no rd_req, outs 4'hF.
REQ-034 rd_data=24'h0C5999 -> out2=4'hE, others per mapping.
